// File: rtl/branch_redirect_unit.sv
`default_nettype none
//==============================================================================
// Module      : branch_redirect_unit
// Description : Sits between execute and fetch. When execute completes a taken
//               branch, JAL or JALR, the unit holds flush_if/flush_id high for
//               FLUSH_CYCLES cycles. It then offers the jump target to fetch on
//               a valid/ready handshake. It also counts completed redirects
//               (saturating) and pulses misalign_err for targets that are not
//               4-byte aligned.
// Ports       : clk, reset (async, active-high)
//               ex_done, ex_jump, ex_target    - execute completion + target
//               fetch_ready                    - fetch accepts redirect_pc
//               redirect_valid, redirect_pc    - redirect offer to fetch
//               flush_if, flush_id             - front-end kill strobes
//               busy                           - execute must hold ex_done low
//               misalign_err                   - one-cycle misaligned pulse
//               redirect_count                 - completed redirects
// Revision    : 1.0 - initial release
//==============================================================================
module branch_redirect_unit #(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_done,
    input  logic                 ex_jump,
    input  logic [XLEN-1:0]      ex_target,
    input  logic                 fetch_ready,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic                 busy,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0]           C_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0]      C_BIT0_MASK  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [3:0]             r_flush_cnt;
    logic [XLEN-1:0]        r_redirect_pc;
    logic                   r_redirect_valid;
    logic                   r_flush;
    logic                   r_busy;
    logic                   r_misalign;
    logic [CNT_WIDTH-1:0]   r_count;

    logic                   w_jump;
    logic [XLEN-1:0]        w_target_q;

    assign w_jump     = ex_done && ex_jump;
    // JALR semantics: bit 0 of the computed target is always discarded.
    assign w_target_q = ex_target & ~C_BIT0_MASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_flush_cnt      <= 4'd0;
            r_redirect_pc    <= '0;
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            r_busy           <= 1'b0;
            r_misalign       <= 1'b0;
            r_count          <= '0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_jump) begin
                        if (w_target_q[1]) begin
                            // Not 4-byte aligned: report it and drop the jump.
                            r_misalign <= 1'b1;
                        end else begin
                            r_redirect_pc <= w_target_q;
                            r_flush_cnt   <= C_FLUSH_LOAD;
                            r_flush       <= 1'b1;
                            r_busy        <= 1'b1;
                            r_state       <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == 4'd0) begin
                        r_flush          <= 1'b0;
                        r_redirect_valid <= 1'b1;
                        r_state          <= ST_REDIRECT;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    // ex_done is not examined here, so a jump arriving on the
                    // handshake cycle is dropped along with any other in-flight one.
                    if (fetch_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_busy           <= 1'b0;
                        r_state          <= ST_IDLE;
                        if (!(&r_count)) begin
                            r_count <= r_count + C_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_redirect_valid <= 1'b0;
                    r_flush          <= 1'b0;
                    r_busy           <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush_if       = r_flush;
    assign flush_id       = r_flush;
    assign busy           = r_busy;
    assign misalign_err   = r_misalign;
    assign redirect_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_branch_redirect_unit
// Description : Self-checking bench for branch_redirect_unit. A timestamp-based
//               reference model (cycles since a jump was accepted) predicts
//               every output after each rising edge. Directed scenarios are
//               followed by a randomized phase.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_branch_redirect_unit;

    localparam int XLEN = 64;
    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            ex_done = 1'b0;
    logic            ex_jump = 1'b0;
    logic [XLEN-1:0] ex_target = '0;
    logic            fetch_ready = 1'b0;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_if;
    logic            flush_id;
    logic            busy;
    logic            misalign_err;
    logic [CW-1:0]   redirect_count;

    int checks = 0;
    int errors = 0;

    // Reference model: a pending redirect is described by its age in cycles.
    // Age 1..FC is the flush window, beyond that the target is offered.
    bit              m_active;
    int              m_age;
    logic [XLEN-1:0] m_pc;
    int              m_count;
    bit              m_mis;

    branch_redirect_unit #(
        .XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .ex_done(ex_done), .ex_jump(ex_jump),
        .ex_target(ex_target), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if(flush_if), .flush_id(flush_id), .busy(busy),
        .misalign_err(misalign_err), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        m_age    = 0;
        m_pc     = '0;
        m_count  = 0;
        m_mis    = 1'b0;
    endtask

    task automatic check_all();
        chk("flush_if",       64'(flush_if),       64'(m_active && m_age <= FC));
        chk("flush_id",       64'(flush_id),       64'(m_active && m_age <= FC));
        chk("busy",           64'(busy),           64'(m_active));
        chk("redirect_valid", 64'(redirect_valid), 64'(m_active && m_age > FC));
        chk("redirect_pc",    redirect_pc,         m_pc);
        chk("misalign_err",   64'(misalign_err),   64'(m_mis));
        chk("redirect_count", 64'(redirect_count), 64'(m_count));
    endtask

    // Advance one clock, update the model from the inputs seen at that edge,
    // then compare 1 time unit after the edge.
    task automatic step();
        bit jmp;
        bit mis_n;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            jmp   = ex_done && ex_jump;
            mis_n = !m_active && jmp && ex_target[1];
            if (m_active) begin
                if (m_age > FC && fetch_ready) begin
                    m_active = 1'b0;
                    if (m_count < CMAX) m_count++;
                end else begin
                    m_age++;
                end
            end else if (jmp && !ex_target[1]) begin
                m_active = 1'b1;
                m_age    = 1;
                m_pc     = {ex_target[XLEN-1:1], 1'b0};
            end
            m_mis = mis_n;
        end
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic jump(input logic [XLEN-1:0] t);
        ex_done   = 1'b1;
        ex_jump   = 1'b1;
        ex_target = t;
        step();
        ex_done   = 1'b0;
        ex_jump   = 1'b0;
    endtask

    // Asynchronous reset asserted between edges, checked before any edge.
    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int hs;
        int n;
        model_clear();

        // Reset state
        #2;
        async_reset();
        steps(2);

        // 1 basic redirect with fetch always ready
        fetch_ready = 1'b1;
        jump(64'h1000);
        chk("t1_flush_c1", 64'(flush_if), 64'd1);
        step();
        chk("t1_flush_c2", 64'(flush_id), 64'd1);
        step();
        chk("t1_valid", 64'(redirect_valid), 64'd1);
        chk("t1_pc", redirect_pc, 64'h1000);
        step();
        chk("t1_valid_drop", 64'(redirect_valid), 64'd0);
        chk("t1_count", 64'(redirect_count), 64'd1);

        // 2 completion without jump
        ex_done = 1'b1; ex_jump = 1'b0; ex_target = 64'h2000;
        step();
        ex_done = 1'b0;
        steps(3);
        chk("t2_count", 64'(redirect_count), 64'd1);

        // 3 bit0 discarded, then a misaligned target
        jump(64'h3001);
        steps(FC);
        chk("t3_pc", redirect_pc, 64'h3000);
        step();
        jump(64'h3002);
        chk("t3_mis", 64'(misalign_err), 64'd1);
        step();
        chk("t3_mis_pulse", 64'(misalign_err), 64'd0);
        chk("t3_count", 64'(redirect_count), 64'd2);

        // 4 back-pressure, with an illegal ex_done during the wait
        fetch_ready = 1'b0;
        jump(64'h5000);
        steps(FC);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ex_done = 1'b1; ex_jump = 1'b1; ex_target = 64'h4000;
            end
            step();
            ex_done = 1'b0; ex_jump = 1'b0;
            chk("t4_pc_hold", redirect_pc, 64'h5000);
            chk("t4_busy", 64'(busy), 64'd1);
        end
        fetch_ready = 1'b1;
        step();
        chk("t4_idle", 64'(busy), 64'd0);
        steps(3);

        // Reset while a redirect is being offered
        fetch_ready = 1'b0;
        jump(64'h6000);
        steps(FC);
        chk("rst_pre_valid", 64'(redirect_valid), 64'd1);
        async_reset();
        chk("rst_valid", 64'(redirect_valid), 64'd0);
        steps(4);

        // 5 reset during the first flush cycle
        fetch_ready = 1'b1;
        jump(64'h7000);
        async_reset();
        chk("t5_flush", 64'(flush_if), 64'd0);
        steps(5);

        // 6 saturation: 17 redirects on a 4-bit counter
        hs = 0;
        for (int k = 0; k < 17; k++) begin
            jump(64'(32'h100 * (k + 1)));
            n = 0;
            while (busy && n < 20) begin
                step();
                n++;
            end
            chk("t6_complete", 64'(busy), 64'd0);
            if (!busy) hs++;
        end
        chk("t6_count", 64'(redirect_count), 64'(CMAX));
        chk("t6_handshakes", 64'(hs), 64'd17);

        // Randomized phase
        async_reset();
        for (int i = 0; i < 400; i++) begin
            ex_done     = ($urandom_range(0, 2) == 0);
            ex_jump     = $urandom_range(0, 1) == 1;
            ex_target   = {$urandom, $urandom};
            fetch_ready = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
